// File: rtl/pdm_mic_ctrl_pkg.sv
// Shared types and helpers for the PDM microphone sequencer.
package pdm_pkg;

  localparam int PCM_W = 16;

  typedef enum logic [2:0] {IDLE, WAKE, DISCARD, RUN, STOP} pdm_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/pdm_mic_ctrl_clk_gen.sv
// MIC_CLK divider with registered edge strobes; optional falling strobe under PDM_FALL_STROBE_EN.
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int CLK_DIV = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic stop_req_i,
  output logic mic_clk_o,
  output logic mic_clk_rising_o,
`ifdef PDM_FALL_STROBE_EN
  output logic mic_clk_falling_o,
`endif
  output logic rise_evt_o,
  output logic period_done_o
);

  localparam int DIV_W = cnt_w(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             mic_q, mic_d;
  logic             rise_q, rise_d;
  logic             tc;

  assign tc = (div_q == DIV_TC);

  // While stopping, the rising toggle is suppressed so the clock parks low.
  always_comb begin
    div_d  = div_q;
    mic_d  = mic_q;
    rise_d = 1'b0;
    if (!run_i) begin
      div_d = '0;
      mic_d = 1'b0;
    end else if (tc) begin
      div_d = '0;
      if (mic_q) begin
        mic_d = 1'b0;
      end else if (!stop_req_i) begin
        mic_d  = 1'b1;
        rise_d = 1'b1;
      end
    end else begin
      div_d = div_q + DIV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      mic_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      mic_q  <= mic_d;
      rise_q <= rise_d;
    end
  end

`ifdef PDM_FALL_STROBE_EN
  logic fall_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      fall_q <= 1'b0;
    end else begin
      fall_q <= mic_q & ~mic_d;
    end
  end

  assign mic_clk_falling_o = fall_q;
`endif

  assign mic_clk_o        = mic_q;
  assign mic_clk_rising_o = rise_q;
  assign rise_evt_o       = run_i & tc & ~mic_q & ~stop_req_i;
  assign period_done_o    = run_i & stop_req_i & tc;

endmodule

// File: rtl/pdm_mic_ctrl.sv
// PDM mic sequencer: wake, decimator flush, then PCM pass-through.
// Optional mic_clk_falling output when PDM_FALL_STROBE_EN is defined.
//
//   state   | meaning
//   IDLE    | mic clock parked low, waiting for enable
//   WAKE    | counting mic clock rising edges for mic power-up
//   DISCARD | dropping decimator samples while the CIC flushes
//   RUN     | forwarding decimator samples with one clk latency
//   STOP    | finishing the current mic clock period before IDLE
module pdm_mic_ctrl
  import pdm_pkg::*;
#(
  parameter int CLK_DIV         = 20,
  parameter int WAKE_PERIODS    = 25000,
  parameter int DISCARD_SAMPLES = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  output logic             mic_clk,
  output logic             mic_clk_rising,
`ifdef PDM_FALL_STROBE_EN
  output logic             mic_clk_falling,
`endif
  input  logic [PCM_W-1:0] pcm_in_data,
  input  logic             pcm_in_valid,
  output logic [PCM_W-1:0] pcm_data,
  output logic             pcm_data_valid,
  output logic             mic_active
);

  localparam int WAKE_W = cnt_w(WAKE_PERIODS);
  localparam int DISC_W = cnt_w(DISCARD_SAMPLES);
  localparam logic [WAKE_W-1:0] WAKE_LAST = WAKE_W'(WAKE_PERIODS - 1);
  localparam logic [WAKE_W-1:0] WAKE_MAX  = WAKE_W'(WAKE_PERIODS);
  localparam logic [DISC_W-1:0] DISC_LAST = DISC_W'(DISCARD_SAMPLES - 1);
  localparam logic [DISC_W-1:0] DISC_MAX  = DISC_W'(DISCARD_SAMPLES);

  pdm_state_t       state_q, state_d;
  logic [WAKE_W-1:0] wake_q, wake_d;
  logic [DISC_W-1:0] disc_q, disc_d;
  logic [PCM_W-1:0]  pcm_q, pcm_d;
  logic              pcm_valid_q, pcm_valid_d;
  logic              clk_run, stop_req, rise_evt, period_done;

  assign clk_run  = (state_q != IDLE);
  assign stop_req = (state_q == STOP);

  pdm_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk               (clk),
    .rst               (rst),
    .run_i             (clk_run),
    .stop_req_i        (stop_req),
    .mic_clk_o         (mic_clk),
    .mic_clk_rising_o  (mic_clk_rising),
`ifdef PDM_FALL_STROBE_EN
    .mic_clk_falling_o (mic_clk_falling),
`endif
    .rise_evt_o        (rise_evt),
    .period_done_o     (period_done)
  );

  always_comb begin
    state_d     = state_q;
    wake_d      = wake_q;
    disc_d      = disc_q;
    pcm_d       = pcm_q;
    pcm_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          state_d = WAKE;
          wake_d  = '0;
          disc_d  = '0;
        end
      end
      WAKE: begin
        if (rise_evt && (wake_q != WAKE_MAX)) wake_d = wake_q + WAKE_W'(1);
        if (!enable) state_d = STOP;
        else if (rise_evt && (wake_q == WAKE_LAST)) state_d = DISCARD;
      end
      DISCARD: begin
        if (pcm_in_valid && (disc_q != DISC_MAX)) disc_d = disc_q + DISC_W'(1);
        if (!enable) state_d = STOP;
        else if (pcm_in_valid && (disc_q == DISC_LAST)) state_d = RUN;
      end
      RUN: begin
        // A sample arriving as enable drops is still forwarded.
        if (pcm_in_valid) begin
          pcm_valid_d = 1'b1;
          pcm_d       = pcm_in_data;
        end
        if (!enable) state_d = STOP;
      end
      STOP: begin
        if (period_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      wake_q      <= '0;
      disc_q      <= '0;
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wake_q      <= wake_d;
      disc_q      <= disc_d;
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
    end
  end

  assign pcm_data       = pcm_q;
  assign pcm_data_valid = pcm_valid_q;
  assign mic_active     = (state_q == RUN);

endmodule

// File: tb/tb_pdm_mic_ctrl.sv
// Bench for pdm_mic_ctrl: timeline reference model plus a PCM scoreboard.
// Checks mic_clk_falling as well when PDM_FALL_STROBE_EN is defined.
module tb_pdm_mic_ctrl;

  localparam int CLK_DIV = 2;
  localparam int WP      = 4;
  localparam int DS      = 3;

  logic        clk = 1'b0;
  logic        rst, enable, pcm_in_valid;
  logic [15:0] pcm_in_data, pcm_data;
  logic        mic_clk, mic_clk_rising, pcm_data_valid, mic_active;
`ifdef PDM_FALL_STROBE_EN
  logic        mic_clk_falling;
`endif

  always #5 clk = ~clk;

  pdm_mic_ctrl #(
    .CLK_DIV         (CLK_DIV),
    .WAKE_PERIODS    (WP),
    .DISCARD_SAMPLES (DS)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .enable          (enable),
    .mic_clk         (mic_clk),
    .mic_clk_rising  (mic_clk_rising),
`ifdef PDM_FALL_STROBE_EN
    .mic_clk_falling (mic_clk_falling),
`endif
    .pcm_in_data     (pcm_in_data),
    .pcm_in_valid    (pcm_in_valid),
    .pcm_data        (pcm_data),
    .pcm_data_valid  (pcm_data_valid),
    .mic_active      (mic_active)
  );

  typedef struct packed {
    int          c;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  bit          chk_en = 1'b0;
  bit          exp_v;

  // Session timeline: wake starts at m_w, discard counting from m_wake_end,
  // forwarding from m_run, enable dropped at m_stop.
  bit          m_idle = 1'b1;
  int          m_w = 0, m_wake_end = 0, m_stop = -1, m_run = -1, m_n = 0;
  logic [15:0] m_pcm = '0;
  bit          m_prev_mic = 1'b0, m_prev_rst = 1'b0, last_v = 1'b0;
  bit          em, er, ea, ef;
  logic [15:0] epcm = '0;

  function automatic bit pred_mic(int c);
    if (m_idle) return 1'b0;
    return (((c - m_w) / CLK_DIV) % 2) == 1;
  endfunction

  function automatic bit running();
    return !m_idle && (m_stop < 0) && (m_run >= 0) && (cyc >= m_run);
  endfunction

  function automatic bit rnd_v(int pct);
    if (last_v) return 1'b0;
    if (!m_idle && ((cyc == m_wake_end - 1) || (cyc == m_wake_end))) return 1'b0;
    return $urandom_range(0, 99) < pct;
  endfunction

  task automatic check_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_w(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %04h expected %04h", name, cyc, act, exp);
    end
  endtask

  // Drive one clk cycle of inputs, derive expected outputs, advance the model.
  task automatic step(bit en, bit v, logic [15:0] d, bit r);
    rst          = r;
    enable       = en;
    pcm_in_valid = v;
    pcm_in_data  = d;
    em   = pred_mic(cyc);
    er   = em && (((cyc - m_w) % CLK_DIV) == 0);
    ea   = !m_idle && (m_run >= 0) && (cyc >= m_run) && ((m_stop < 0) || (cyc <= m_stop));
    ef   = m_prev_mic && !em && !m_prev_rst;
    epcm = m_pcm;
    m_prev_mic = em;
    m_prev_rst = r;
    last_v     = v;
    if (r) begin
      m_idle = 1'b1;
      m_pcm  = '0;
    end else if (m_idle) begin
      if (en) begin
        m_idle     = 1'b0;
        m_w        = cyc + 1;
        m_wake_end = m_w + CLK_DIV * (2 * WP - 1);
        m_stop     = -1;
        m_run      = -1;
        m_n        = 0;
      end
    end else if (m_stop < 0) begin
      if (v && (cyc >= m_wake_end)) begin
        if (m_run < 0) begin
          m_n++;
          if ((m_n == DS) && en) m_run = cyc + 1;
        end else begin
          sb.push_back('{c: cyc + 1, data: d});
          m_pcm = d;
        end
      end
      if (!en) m_stop = cyc;
    end else if (((cyc - m_w) % CLK_DIV) == CLK_DIV - 1) begin
      m_idle = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_rand(int n, bit en, int pct);
    for (int i = 0; i < n; i++) step(en, rnd_v(pct), 16'($urandom), 1'b0);
  endtask

  task automatic wait_running(int budget, string name);
    int k = 0;
    while (!(running() && pred_mic(cyc)) && (k < budget)) begin
      step(1'b1, rnd_v(30), 16'($urandom), 1'b0);
      k++;
    end
    if (k >= budget) begin
      checks++;
      errors++;
      $display("FAIL %s: RUN with mic_clk high not reached, got timeout required %0d cycles max", name, budget);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_bit("mic_clk", mic_clk, em);
      check_bit("mic_clk_rising", mic_clk_rising, er);
      check_bit("mic_active", mic_active, ea);
      check_w("pcm_data_hold", pcm_data, epcm);
`ifdef PDM_FALL_STROBE_EN
      check_bit("mic_clk_falling", mic_clk_falling, ef);
`endif
      exp_v = (sb.size() > 0) && (sb[0].c == cyc);
      check_bit("pcm_data_valid", pcm_data_valid, exp_v);
      if (exp_v) begin
        e = sb.pop_front();
        if (pcm_data_valid) check_w("pcm_sample", pcm_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    step(1'b0, 1'b0, 16'h0000, 1'b1);
    chk_en = 1'b1;
    // Samples while idle must be ignored.
    step(1'b0, 1'b1, 16'h1234, 1'b0);
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h5678, 1'b0);

    // Wake with stray samples, then the fixed 1..4 sequence into DISCARD/RUN.
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    while (cyc < m_wake_end - 1) step(1'b1, rnd_v(30), 16'($urandom), 1'b0);
    while (cyc < m_wake_end + 2) step(1'b1, 1'b0, 16'h0000, 1'b0);
    for (int j = 1; j <= 4; j++) begin
      step(1'b1, 1'b1, 16'(j), 1'b0);
      step(1'b1, 1'b0, 16'h0000, 1'b0);
    end
    run_rand(40, 1'b1, 35);

    // Stop from RUN with mic_clk high; a sample during STOP is not emitted.
    wait_running(50, "stop_a");
    step(1'b0, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'h7FFF, 1'b0);
    run_rand(12, 1'b0, 30);

    // Enable drops together with a RUN sample, then re-enable mid-STOP.
    wait_running(200, "wake_b");
    run_rand(20, 1'b1, 35);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    step(1'b0, 1'b1, 16'($urandom), 1'b0);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    wait_running(200, "rewake");
    run_rand(20, 1'b1, 35);

    // Reset while running with mic_clk high, sample in flight.
    wait_running(50, "rst_run");
    step(1'b1, !last_v, 16'hBEEF, 1'b1);
    step(1'b1, 1'b0, 16'h0000, 1'b0);
    wait_running(200, "after_rst");
    run_rand(15, 1'b1, 35);

    // Random sessions, stopping anywhere in WAKE, DISCARD or RUN.
    for (int s = 0; s < 8; s++) begin
      run_rand($urandom_range(3, 70), 1'b1, 35);
      run_rand($urandom_range(1, 12), 1'b0, 35);
    end
    run_rand(12, 1'b0, 0);
    chk_en = 1'b0;

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending samples required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
